// File: rtl/lif_neuron.sv
// lif_neuron -- leaky integrate-and-fire neuron.
//
// Each clock the signed weights of every input that spiked are summed and
// added to the membrane potential (minus an optional leak). When the
// saturated result reaches THRESHOLD the neuron emits a one-cycle spike,
// resets its potential to zero and, if REFRACTORY > 0, ignores its inputs
// for exactly REFRACTORY cycles.
//
// Build option:
//   LIF_LEAK_EN  defined   -> leak = potential >>> LEAK_SHIFT is subtracted
//                undefined -> pure integrate-and-fire, no shifter built
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   enable       in   integration enable (0 -> IDLE, potential held)
//   clear        in   synchronous potential/refractory clear
//   spikes_in    in   [N_INPUTS]          one spike per set bit this cycle
//   weights      in   [N_INPUTS*WIDTH]    signed weight i at [i*WIDTH +: WIDTH]
//   spike_out    out  registered one-cycle fire pulse
//   potential    out  [POT_WIDTH]        signed membrane potential
//   refractory   out  high while in REFRACT
//   spike_count  out  [COUNT_WIDTH]      fires since reset, wrapping
module lif_neuron #(
  parameter int N_INPUTS    = 4,
  parameter int WIDTH       = 8,
  parameter int POT_WIDTH   = 12,
  parameter int THRESHOLD   = 100,
  parameter int LEAK_SHIFT  = 3,
  parameter int REFRACTORY  = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [N_INPUTS-1:0]           spikes_in,
  input  logic [N_INPUTS*WIDTH-1:0]     weights,
  output logic                          spike_out,
  output logic [POT_WIDTH-1:0]          potential,
  output logic                          refractory,
  output logic [COUNT_WIDTH-1:0]        spike_count
);

  // Two guard bits: enough headroom for potential - leak + sum before
  // saturation, given POT_WIDTH >= WIDTH + clog2(N_INPUTS) + 1.
  localparam int SUM_W = POT_WIDTH + 2;

  localparam logic signed [SUM_W-1:0] POT_MAX    = {3'b000, {(POT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] POT_MIN    = {3'b111, {(POT_WIDTH-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] THRESH_EXT = SUM_W'(THRESHOLD);
  localparam logic [7:0]              REFR_LOAD  = 8'(REFRACTORY);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INTEGRATE = 2'd1,
    REFRACT   = 2'd2
  } state_t;

  state_t                   state_reg;
  logic [POT_WIDTH-1:0]     potential_reg;
  logic                     spike_reg;
  logic                     refr_reg;
  logic [7:0]               refr_cnt_reg;
  logic [COUNT_WIDTH-1:0]   spike_count_reg;

  // Elaboration-time parameter sanity checks.
  generate
    if (LEAK_SHIFT < 1 || LEAK_SHIFT > POT_WIDTH - 1) begin : g_bad_leak_shift
      $error("lif_neuron: LEAK_SHIFT out of range");
    end
    if (THRESHOLD < 1) begin : g_bad_threshold
      $error("lif_neuron: THRESHOLD must be positive");
    end
  endgenerate

  // Per-input contribution: sign-extended weight when that input spiked.
  logic signed [SUM_W-1:0] term [N_INPUTS];

  genvar gi;
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : g_term
      logic [WIDTH-1:0] w;
      assign w        = weights[gi*WIDTH +: WIDTH];
      assign term[gi] = spikes_in[gi] ? {{(SUM_W-WIDTH){w[WIDTH-1]}}, w} : '0;
    end
  endgenerate

  logic signed [SUM_W-1:0] sum_acc;
  always_comb begin
    sum_acc = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      sum_acc = sum_acc + term[i];
    end
  end

  logic signed [SUM_W-1:0] pot_ext;
  logic signed [SUM_W-1:0] leak;
  assign pot_ext = {{2{potential_reg[POT_WIDTH-1]}}, potential_reg};

`ifdef LIF_LEAK_EN
  assign leak = pot_ext >>> LEAK_SHIFT;
`else
  assign leak = '0;
`endif

  logic signed [SUM_W-1:0] next_full;
  logic signed [SUM_W-1:0] next_sat;
  logic                    fire;

  always_comb begin
    next_full = pot_ext - leak + sum_acc;
    next_sat  = next_full;
    if (next_full > POT_MAX) begin
      next_sat = POT_MAX;
    end else if (next_full < POT_MIN) begin
      next_sat = POT_MIN;
    end
    fire = (next_sat >= THRESH_EXT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      potential_reg   <= '0;
      spike_reg       <= 1'b0;
      refr_reg        <= 1'b0;
      refr_cnt_reg    <= '0;
      spike_count_reg <= '0;
    end else if (clear) begin
      // Clear beats a simultaneous fire: no spike, count untouched.
      state_reg     <= enable ? INTEGRATE : IDLE;
      potential_reg <= '0;
      spike_reg     <= 1'b0;
      refr_reg      <= 1'b0;
      refr_cnt_reg  <= '0;
    end else if (!enable) begin
      state_reg    <= IDLE;
      spike_reg    <= 1'b0;
      refr_reg     <= 1'b0;
      refr_cnt_reg <= '0;
    end else begin
      case (state_reg)
        // IDLE with enable high integrates on the same edge it leaves IDLE,
        // so inputs always take effect one cycle after they are sampled.
        IDLE, INTEGRATE: begin
          if (fire) begin
            spike_reg       <= 1'b1;
            potential_reg   <= '0;
            spike_count_reg <= spike_count_reg + COUNT_WIDTH'(1);
            if (REFRACTORY > 0) begin
              state_reg    <= REFRACT;
              refr_reg     <= 1'b1;
              refr_cnt_reg <= REFR_LOAD;
            end else begin
              state_reg    <= INTEGRATE;
              refr_reg     <= 1'b0;
              refr_cnt_reg <= '0;
            end
          end else begin
            state_reg     <= INTEGRATE;
            spike_reg     <= 1'b0;
            refr_reg      <= 1'b0;
            potential_reg <= next_sat[POT_WIDTH-1:0];
          end
        end
        REFRACT: begin
          spike_reg     <= 1'b0;
          potential_reg <= '0;
          // Leaving on the edge the counter reaches zero gives exactly
          // REFRACTORY cycles spent in REFRACT.
          if (refr_cnt_reg <= 8'd1) begin
            refr_cnt_reg <= '0;
            state_reg    <= INTEGRATE;
            refr_reg     <= 1'b0;
          end else begin
            refr_cnt_reg <= refr_cnt_reg - 8'd1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          spike_reg     <= 1'b0;
          refr_reg      <= 1'b0;
          refr_cnt_reg  <= '0;
          potential_reg <= '0;
        end
      endcase
    end
  end

  assign spike_out   = spike_reg;
  assign potential   = potential_reg;
  assign refractory  = refr_reg;
  assign spike_count = spike_count_reg;

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire neuron that consumes the spike trains produced by the rate-coding divider stages of the SNN perceptron. Each clock it sums the signed synaptic weights of all inputs that spiked, applies optional leak, and fires a one-cycle output spike when the membrane potential reaches threshold, followed by a refractory period. Its output spike train feeds the perceptron's classification and readout logic.

## Interface
- N_INPUTS, 4: number of presynaptic spike inputs.
- WIDTH, 8: signed weight width per input.
- POT_WIDTH, 12: signed membrane potential width; must be at least WIDTH + clog2(N_INPUTS) + 1.
- THRESHOLD, 100: signed firing threshold, with 0 < THRESHOLD <= 2^(POT_WIDTH-1)-1.
- LEAK_SHIFT, 3: leak amount is the potential arithmetically right-shifted by LEAK_SHIFT (range 1..POT_WIDTH-1).
- REFRACTORY, 2: cycles the neuron ignores input after firing (range 0..255).
- COUNT_WIDTH, 16: width of the fired-spike counter.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk in 1: clock; all state updates on the rising edge.
- rst in 1: asynchronous, active-high reset.
- enable in 1: integration enable.
- clear in 1: synchronous potential clear.
- spikes_in in N_INPUTS: spike levels; bit i asserted means one spike from input i in this cycle.
- weights in N_INPUTS*WIDTH: packed signed weights, with weight i at bits [i*WIDTH +: WIDTH].
- spike_out out 1: registered one-cycle fire pulse.
- potential out POT_WIDTH: signed membrane potential register.
- refractory out 1: high while in the REFRACT state.
- spike_count out COUNT_WIDTH: number of fires since reset; wraps modulo 2^COUNT_WIDTH.

## Operation
- States: IDLE, INTEGRATE, REFRACT.
- IDLE:
  - Entered from reset, or whenever enable=0.
  - potential holds its value.
  - Moves to INTEGRATE on the edge where enable=1.
- INTEGRATE:
  - sum = signed sum of weight i over every bit i set in spikes_in, sign-extended to POT_WIDTH+2.
  - leak = potential >>> LEAK_SHIFT, arithmetic shift.
  - next = potential - leak + sum, saturated to [-2^(POT_WIDTH-1), 2^(POT_WIDTH-1)-1].
  - If next >= THRESHOLD: spike_out=1, potential=0, spike_count increments. If REFRACTORY>0, go to REFRACT with the counter loaded to REFRACTORY; otherwise stay in INTEGRATE.
  - Otherwise: potential=next and spike_out=0.
- REFRACT:
  - spikes_in is ignored and potential is held at 0.
  - The counter decrements each cycle; return to INTEGRATE on the edge where it reaches 0, giving exactly REFRACTORY cycles in REFRACT.
- Priority, highest first:
  1. rst
  2. clear: potential=0, spike_out=0, counter=0, go to INTEGRATE if enable else IDLE.
  3. enable=0: go to IDLE, spike_out=0, refractory counter cleared.
  4. The state's normal action.
- A fire decision and clear in the same cycle: clear wins, no spike, spike_count unchanged.

## Timing
- Reset values: spike_out=0, potential=0, refractory=0, spike_count=0, state IDLE.
- Reset is asynchronous: outputs go to their reset values immediately, including mid-refractory or during spike_out.
- Latency: spikes_in sampled at rising edge k affects potential and spike_out from edge k, i.e. they are visible in cycle k+1.
- spike_out is never high for two consecutive cycles when REFRACTORY>0. With REFRACTORY=0, back-to-back fires are legal.
- refractory is asserted on the same edge as spike_out and deasserts on the edge the state returns to INTEGRATE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- LIF_LEAK_EN defined: leak term applied as described above.
- LIF_LEAK_EN undefined: leak=0, giving a pure integrate-and-fire neuron. LEAK_SHIFT is ignored and no shifter logic is generated.

## Test plan
All scenarios use the default parameters.
- Reset: assert rst mid-run → spike_out, potential, refractory and spike_count are 0 immediately; state is IDLE after rst is released.
- Leak build, weight0=30, spikes_in=4'b0001, enable=1 → potential 30, 57, 80; fire on the 4th edge (next=100); refractory high for 2 cycles; potential then restarts at 30; period 6 cycles.
- No-leak build, all weights -128, spikes_in=4'b1111 → potential -512, -1024, -1536, -2048, then holds at -2048 (saturation); no spike.
- No-leak build, weight0=127, spikes_in=1, clear asserted on the cycle the potential would reach 127 → potential 0, no spike_out, spike_count unchanged.
- No-leak build, enable dropped for 5 cycles with potential=60 → potential holds 60 and state is IDLE; after re-enable with weight0=40 → fires on the next edge.
- COUNT_WIDTH=4, REFRACTORY=0, weight0=100 driven continuously → spike_out high every cycle; spike_count wraps from 15 to 0 on the 16th fire.
